// File: rtl/sha256_padder_if.sv
// Padded-block stream from the SHA-256 padder to the compression core.
// The master drives the block and its sideband; the slave returns ready.
interface sha256_padder_if #(
    parameter int MAX_BITS = 1024
);
    localparam int MAX_BLOCKS = (MAX_BITS + 64) / 512 + 1;
    localparam int IDX_W      = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

    logic [511:0]     block;
    logic             block_valid;
    logic             block_ready;
    logic             block_last;
    logic [IDX_W-1:0] block_idx;

    modport master (
        output block, block_valid, block_last, block_idx,
        input  block_ready
    );

    modport slave (
        input  block, block_valid, block_last, block_idx,
        output block_ready
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: latches one message of up to MAX_BITS bits and streams
// its padded 512-bit blocks (M || 1 || 0* || 64-bit length) over a valid/ready link.
//
// state  | meaning
// S_IDLE | waiting for start; outputs quiet
// S_EMIT | presenting block r_k of r_nblk, advancing on each handshake
module sha256_padder #(
    parameter  int MAX_BITS   = 1024,
    localparam int LEN_W      = $clog2(MAX_BITS + 1),
    localparam int MAX_BLOCKS = (MAX_BITS + 64) / 512 + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MAX_BITS-1:0] bits,
    input  logic [LEN_W-1:0]    bits_width,
    sha256_padder_if.master     blk,
    output logic                busy,
    output logic                err_len
);
    localparam int IDX_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
    localparam int NB_W  = $clog2(MAX_BLOCKS + 1);
    localparam int PADW  = 512 * MAX_BLOCKS;
    localparam logic [PADW-1:0] TOP_BIT = {1'b1, {(PADW-1){1'b0}}};

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t             r_state;
    logic [MAX_BITS-1:0] r_msg;
    logic [LEN_W-1:0]   r_len;
    logic [NB_W-1:0]    r_nblk;
    logic [IDX_W-1:0]   r_k;
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_err;

    logic               w_len_ok;
    logic [NB_W-1:0]    w_nblk_new;
    logic [MAX_BITS-1:0] w_msg_new;
    logic [PADW-1:0]    w_stream;
    logic [PADW-1:0]    w_sel;

    assign w_len_ok   = (32'(bits_width) <= 32'(MAX_BITS));
    assign w_nblk_new = NB_W'((32'(bits_width) + 32'd64) / 32'd512 + 32'd1);
    // Left-align the message; the shift also drops any bits above bits_width.
    assign w_msg_new  = bits << (32'(MAX_BITS) - 32'(bits_width));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_msg   <= '0;
            r_len   <= '0;
            r_nblk  <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_msg   <= w_msg_new;
                            r_len   <= bits_width;
                            r_nblk  <= w_nblk_new;
                            r_k     <= '0;
                            r_last  <= (w_nblk_new == NB_W'(1));
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_EMIT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (r_valid && blk.block_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                            r_k     <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_k    <= r_k + IDX_W'(1);
                            r_last <= ((32'(r_k) + 32'd2) == 32'(r_nblk));
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Whole padded stream, first bit at PADW-1; the length field sits at the end of block N-1.
    always_comb begin
        w_stream = {r_msg, {(PADW-MAX_BITS){1'b0}}}
                 | (TOP_BIT >> r_len)
                 | (PADW'(r_len) << (32'(PADW) - 32'd512 * 32'(r_nblk)));
        w_sel    = w_stream << (32'd512 * 32'(r_k));
    end

    assign blk.block       = r_valid ? w_sel[PADW-1 -: 512] : '0;
    assign blk.block_valid = r_valid;
    assign blk.block_last  = r_last;
    assign blk.block_idx   = r_k;
    assign busy            = r_busy;
    assign err_len         = r_err;
endmodule

// File: tb/tb_sha256_padder.sv
// Testbench for sha256_padder: scenario tasks checked against a bit-queue padding model.
module tb_sha256_padder;
    localparam int MAX_BITS = 1024;
    localparam int LEN_W    = 11;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [MAX_BITS-1:0] bits = '0;
    logic [LEN_W-1:0]    bits_width = '0;
    logic                busy;
    logic                err_len;

    int n_pass = 0;
    int n_total = 0;
    bit ref_q[$];

    sha256_padder_if #(.MAX_BITS(MAX_BITS)) bif ();

    sha256_padder #(.MAX_BITS(MAX_BITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bits       (bits),
        .bits_width (bits_width),
        .blk        (bif),
        .busy       (busy),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: append bits one at a time exactly as the padding rule reads.
    function automatic void build_ref(input logic [MAX_BITS-1:0] m, input int L);
        logic [63:0] lv;
        ref_q.delete();
        for (int p = 0; p < L; p++) ref_q.push_back(m[L-1-p]);
        ref_q.push_back(1'b1);
        while (ref_q.size() % 512 != 448) ref_q.push_back(1'b0);
        lv = 64'(L);
        for (int i = 63; i >= 0; i--) ref_q.push_back(lv[i]);
    endfunction

    function automatic logic [511:0] ref_block(input int k);
        logic [511:0] b;
        for (int i = 0; i < 512; i++) b[511-i] = ref_q[512*k + i];
        return b;
    endfunction

    task automatic rand_msg(output logic [MAX_BITS-1:0] m);
        for (int w = 0; w < MAX_BITS/32; w++) m[32*w +: 32] = $urandom;
    endtask

    // Returns at the falling edge one cycle after start, inputs already scrambled.
    task automatic pulse_start(input logic [MAX_BITS-1:0] m, input int L);
        @(negedge clk);
        bits       = m;
        bits_width = LEN_W'(L);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        bits       = ~m;
        bits_width = LEN_W'($urandom);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (bif.block_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bif.block_valid); else n_pass++;
        n_total++; if (bif.block !== 512'd0) $display("FAIL reset_block: got %h want 0", bif.block); else n_pass++;
        n_total++; if ({bif.block_last, bif.block_idx, busy, err_len} !== 5'd0)
            $display("FAIL reset_flags: got last=%0b idx=%0d busy=%0b err=%0b want all 0", bif.block_last, bif.block_idx, busy, err_len);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc;
        logic [MAX_BITS-1:0] m;
        logic [511:0] exp_b;
        m = '0;
        m[23:0] = 24'h616263;
        exp_b = {32'h61626380, 416'd0, 64'h18};
        bif.block_ready = 1'b1;
        pulse_start(m, 24);
        n_total++; if (bif.block_valid !== 1'b1 || busy !== 1'b1) $display("FAIL abc_valid: got valid=%0b busy=%0b want 1 1", bif.block_valid, busy); else n_pass++;
        n_total++; if (bif.block !== exp_b) $display("FAIL abc_block: got %h want %h", bif.block, exp_b); else n_pass++;
        n_total++; if (bif.block_last !== 1'b1 || bif.block_idx !== 2'd0) $display("FAIL abc_last_idx: got last=%0b idx=%0d want 1 0", bif.block_last, bif.block_idx); else n_pass++;
        @(negedge clk);
        n_total++; if (bif.block_valid !== 1'b0 || busy !== 1'b0) $display("FAIL abc_done: got valid=%0b busy=%0b want 0 0", bif.block_valid, busy); else n_pass++;
        bif.block_ready = 1'b0;
    endtask

    task automatic test_len448;
        logic [MAX_BITS-1:0] m;
        logic [511:0] e0, e1;
        rand_msg(m);
        for (int i = 0; i < 56; i++) m[8*i +: 8] = 8'h61;
        e0 = '0;
        for (int i = 0; i < 56; i++) e0[64 + 8*i +: 8] = 8'h61;
        e0[63:0] = 64'h8000_0000_0000_0000;
        e1 = {448'd0, 64'h1C0};
        bif.block_ready = 1'b1;
        pulse_start(m, 448);
        n_total++; if (bif.block !== e0) $display("FAIL l448_block0: got %h want %h", bif.block, e0); else n_pass++;
        n_total++; if (bif.block_last !== 1'b0 || bif.block_idx !== 2'd0) $display("FAIL l448_flags0: got last=%0b idx=%0d want 0 0", bif.block_last, bif.block_idx); else n_pass++;
        @(negedge clk);
        n_total++; if (bif.block !== e1) $display("FAIL l448_block1: got %h want %h", bif.block, e1); else n_pass++;
        n_total++; if (bif.block_last !== 1'b1 || bif.block_idx !== 2'd1) $display("FAIL l448_flags1: got last=%0b idx=%0d want 1 1", bif.block_last, bif.block_idx); else n_pass++;
        @(negedge clk);
        n_total++; if (bif.block_valid !== 1'b0 || busy !== 1'b0) $display("FAIL l448_done: got valid=%0b busy=%0b want 0 0", bif.block_valid, busy); else n_pass++;
        bif.block_ready = 1'b0;
    endtask

    // Boundary lengths plus random ones; ready mode 0=always, 1=random, 2=pattern 0,0,1.
    task automatic test_messages;
        int lens[$];
        logic [MAX_BITS-1:0] m;
        int L, nb, hs, cyc, mode;
        logic r;
        lens = '{0, 1, 24, 447, 448, 511, 512, 959, 960, 1023, 1024, 1024};
        for (int i = 0; i < 9; i++) lens.push_back(int'($urandom_range(0, MAX_BITS)));
        for (int t = 0; t < lens.size(); t++) begin
            L = lens[t];
            mode = t % 3;
            rand_msg(m);
            build_ref(m, L);
            nb = ref_q.size() / 512;
            pulse_start(m, L);
            hs = 0;
            cyc = 0;
            while (hs < nb && cyc < 64) begin
                case (mode)
                    0: r = 1'b1;
                    1: r = 1'($urandom);
                    default: r = (cyc % 3 == 2);
                endcase
                bif.block_ready = r;
                n_total++; if (bif.block_valid !== 1'b1 || busy !== 1'b1)
                    $display("FAIL msg_valid L=%0d k=%0d: got valid=%0b busy=%0b want 1 1", L, hs, bif.block_valid, busy);
                else n_pass++;
                n_total++; if (bif.block !== ref_block(hs))
                    $display("FAIL msg_block L=%0d k=%0d: got %h want %h", L, hs, bif.block, ref_block(hs));
                else n_pass++;
                n_total++; if (bif.block_idx !== 2'(hs) || bif.block_last !== (hs == nb - 1))
                    $display("FAIL msg_idx_last L=%0d: got idx=%0d last=%0b want idx=%0d last=%0b", L, bif.block_idx, bif.block_last, hs, (hs == nb - 1));
                else n_pass++;
                if (r) hs++;
                @(negedge clk);
                cyc++;
            end
            bif.block_ready = 1'b0;
            n_total++; if (hs !== nb) $display("FAIL msg_count L=%0d: got %0d handshakes want %0d", L, hs, nb); else n_pass++;
            n_total++; if (bif.block_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL msg_end L=%0d: got valid=%0b busy=%0b want 0 0", L, bif.block_valid, busy);
            else n_pass++;
        end
    endtask

    task automatic test_err_len;
        int bad[2];
        bad = '{1025, 2047};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bits_width = LEN_W'(bad[i]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_total++; if (err_len !== 1'b1) $display("FAIL err_pulse L=%0d: got %0b want 1", bad[i], err_len); else n_pass++;
            n_total++; if (bif.block_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL err_idle L=%0d: got valid=%0b busy=%0b want 0 0", bad[i], bif.block_valid, busy);
            else n_pass++;
            @(negedge clk);
            n_total++; if (err_len !== 1'b0 || bif.block_valid !== 1'b0)
                $display("FAIL err_once L=%0d: got err=%0b valid=%0b want 0 0", bad[i], err_len, bif.block_valid);
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy;
        logic [MAX_BITS-1:0] m, m2;
        rand_msg(m);
        rand_msg(m2);
        build_ref(m, 1024);
        bif.block_ready = 1'b0;
        pulse_start(m, 1024);
        bits = m2;
        bits_width = 11'd100;
        start = 1'b1;
        @(negedge clk);
        bits_width = 11'd1500;
        @(negedge clk);
        start = 1'b0;
        n_total++; if (err_len !== 1'b0) $display("FAIL busy_no_err: got %0b want 0", err_len); else n_pass++;
        bif.block_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (bif.block !== ref_block(k) || bif.block_idx !== 2'(k))
                $display("FAIL busy_block k=%0d: got idx=%0d %h want %h", k, bif.block_idx, bif.block, ref_block(k));
            else n_pass++;
            @(negedge clk);
        end
        bif.block_ready = 1'b0;
        n_total++; if (bif.block_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL busy_end: got valid=%0b busy=%0b want 0 0", bif.block_valid, busy);
        else n_pass++;
        @(negedge clk);
        n_total++; if (bif.block_valid !== 1'b0) $display("FAIL busy_no_second: got valid=%0b want 0", bif.block_valid); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [MAX_BITS-1:0] m;
        rand_msg(m);
        bif.block_ready = 1'b1;
        pulse_start(m, 1024);
        @(negedge clk);
        bif.block_ready = 1'b0;
        n_total++; if (bif.block_idx !== 2'd1) $display("FAIL rmid_idx: got %0d want 1", bif.block_idx); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++; if (bif.block_valid !== 1'b0 || busy !== 1'b0 || bif.block !== 512'd0)
            $display("FAIL rmid_outputs: got valid=%0b busy=%0b block=%h want 0", bif.block_valid, busy, bif.block);
        else n_pass++;
        n_total++; if (bif.block_idx !== 2'd0 || bif.block_last !== 1'b0)
            $display("FAIL rmid_flags: got idx=%0d last=%0b want 0 0", bif.block_idx, bif.block_last);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (bif.block_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rmid_idle: got valid=%0b busy=%0b want 0 0", bif.block_valid, busy);
        else n_pass++;
    endtask

    initial begin
        bif.block_ready = 1'b0;
        test_reset;
        test_abc;
        test_len448;
        test_messages;
        test_err_len;
        test_start_while_busy;
        test_reset_mid;
        test_abc;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
